// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back / write-allocate data cache between the MEM stage and line-wide memory.
// Latency: hits return load data combinationally with no wait cycles; a miss stalls for MISS, optional WRITEBACK, REFILL and one REFILLOK bubble, then replays as a hit.
// Backpressure: p1_stall_o holds the pipeline while a request misses or the FSM is busy; memory is paced by registered mem_enable_o/mem_write_o and a one-cycle mem_ack_i.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   mem_*                        line-wide memory side (refill data in, victim line/address out, enable/write, ack)
//   p1_*                         pipeline side (32-bit load/store, word-aligned byte address, stall)
//   acc_cnt_o, miss_cnt_o        completed-access and miss counters (wrap modulo 2^32)
module dcache_2way_top #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [31:0]       p1_data_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       acc_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILLOK} state_t;

    state_t state_q, state_d;
    logic   en_q, en_d, wr_q, wr_d;
    logic   victim_q;

    logic [TAG_W-1:0]  tag_q  [SETS][2];
    logic [LINE_W-1:0] data_q [SETS][2];
    logic [SETS-1:0][1:0] valid_q;
    logic [SETS-1:0][1:0] dirty_q;
    logic [SETS-1:0]      lru_q;     // way to evict next when both ways are valid

    logic [31:0] acc_q, miss_q;

    // Address split
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic [1:0]        unused_addr_lsb;

    assign req_tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx             = p1_addr_i[OFF_W +: IDX_W];
    assign wsel            = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_lsb = p1_addr_i[1:0];

    logic req, is_store, hit_w0, hit_w1, hit, hit_way, acc_fire, refill_fire, victim_d;
    logic [LINE_W-1:0] hit_line;

    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_store = p1_MemWrite_i;
    assign hit_w0   = valid_q[idx][0] & (tag_q[idx][0] == req_tag);
    assign hit_w1   = valid_q[idx][1] & (tag_q[idx][1] == req_tag);
    assign hit      = (state_q == IDLE) & (hit_w0 | hit_w1);
    assign hit_way  = hit_w1;
    assign hit_line = data_q[idx][hit_way];

    assign acc_fire    = req & hit;
    assign refill_fire = (state_q == REFILL) & mem_ack_i;

    // Fill an empty way before evicting; otherwise follow the LRU bit.
    assign victim_d = !valid_q[idx][0] ? 1'b0 :
                      !valid_q[idx][1] ? 1'b1 : lru_q[idx];

    assign p1_data_o    = hit_line[{wsel, 5'd0} +: 32];
    assign p1_stall_o   = req & ~hit;
    assign mem_data_o   = data_q[idx][victim_q];
    assign mem_addr_o   = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}}
                                                 : {req_tag, idx, {OFF_W{1'b0}}};
    assign mem_enable_o = en_q;
    assign mem_write_o  = wr_q;
    assign acc_cnt_o    = acc_q;
    assign miss_cnt_o   = miss_q;

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) state_d = MISS;
            end
            MISS: begin
                en_d = 1'b1;
                if (valid_q[idx][victim_q] && dirty_q[idx][victim_q]) begin
                    state_d = WRITEBACK;
                    wr_d    = 1'b1;
                end else begin
                    state_d = REFILL;
                    wr_d    = 1'b0;
                end
            end
            WRITEBACK: begin
                // Enable stays up across the writeback-to-refill handoff.
                if (mem_ack_i) begin
                    state_d = REFILL;
                    wr_d    = 1'b0;
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d = REFILLOK;
                    en_d    = 1'b0;
                end
            end
            REFILLOK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            victim_q <= 1'b0;
            acc_q    <= 32'd0;
            miss_q   <= 32'd0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            if (state_q == IDLE && req && !hit) begin
                victim_q <= victim_d;
                miss_q   <= miss_q + 32'd1;
            end
            if (acc_fire) begin
                acc_q      <= acc_q + 32'd1;
                lru_q[idx] <= ~hit_way;
                if (is_store) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (refill_fire) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and data contents need no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (refill_fire) begin
            tag_q[idx][victim_q]  <= req_tag;
            data_q[idx][victim_q] <= mem_data_i;
        end else if (acc_fire && is_store) begin
            data_q[idx][hit_way][{wsel, 5'd0} +: 32] <= p1_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_2way_top.sv
// Self-checking bench for dcache_2way_top.
// A recency-list cache model predicts hits, evictions and memory traffic; a responder acks memory requests.
// Directed scenarios add literal expectations that pin the model.
module tb_dcache_2way_top;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o, mem_write_o;
    logic [31:0]       p1_data_i = '0;
    logic [ADDR_W-1:0] p1_addr_i = '0;
    logic              p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [31:0]       acc_cnt_o, miss_cnt_o;

    dcache_2way_top #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .acc_cnt_o(acc_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- memory images ----------------
    logic [255:0] bus_mem [int unsigned];   // written by the DUT through the responder
    logic [255:0] ref_mem [int unsigned];   // written by the model's predicted writebacks

    function automatic logic [255:0] default_line(input int unsigned la);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = la ^ (32'h01010101 * k) ^ 32'h5A000000;
        return l;
    endfunction

    function automatic logic [255:0] bus_line(input int unsigned la);
        if (bus_mem.exists(la)) return bus_mem[la];
        return default_line(la);
    endfunction

    function automatic logic [255:0] ref_line(input int unsigned la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return default_line(la);
    endfunction

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] dat;
    } txn_t;

    txn_t obs_q[$];
    txn_t exp_q[$];

    function automatic txn_t obs_at(input int i);
        txn_t t;
        t = '0;
        if (i < obs_q.size()) t = obs_q[i];
        return t;
    endfunction

    // ---------------- memory responder ----------------
    bit   auto_mem = 1'b1;
    txn_t rsp_t;
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (auto_mem && rst_i && mem_enable_o) begin
                rsp_t.wr   = mem_write_o;
                rsp_t.addr = mem_addr_o;
                rsp_t.dat  = mem_data_o;
                obs_q.push_back(rsp_t);
                check("mem_addr_aligned", mem_addr_o[4:0], 5'd0);
                repeat (2) begin
                    @(negedge clk_i);
                    check("mem_req_stable", {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, rsp_t.wr, rsp_t.addr});
                end
                if (rsp_t.wr) bus_mem[rsp_t.addr] = rsp_t.dat;
                else          mem_data_i = bus_line(rsp_t.addr);
                mem_ack_i = 1'b1;
                @(negedge clk_i);
                mem_ack_i = 1'b0;
            end
        end
    end

    // ---------------- behavioural cache model ----------------
    // Each set is a recency list of resident line addresses, most recent first.
    logic [31:0]  rec [SETS][$];
    logic [255:0] cline [int unsigned];
    bit           cdirty [int unsigned];
    int unsigned  m_acc = 0, m_miss = 0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) rec[s].delete();
        cline.delete();
        cdirty.delete();
        m_acc  = 0;
        m_miss = 0;
        exp_q.delete();
    endtask

    task automatic model_access(input logic [31:0] addr, input bit store, input logic [31:0] wdata,
                                output bit was_hit, output logic [31:0] rdata);
        int unsigned  la;
        int           set, w, pos;
        logic [31:0]  v;
        logic [255:0] l;
        txn_t         t;
        la  = addr & ~32'h1F;
        set = int'((addr >> 5) % SETS);
        w   = int'((addr >> 2) & 7);
        pos = -1;
        for (int i = 0; i < rec[set].size(); i++) if (rec[set][i] == la) pos = i;
        was_hit = (pos >= 0);
        if (pos >= 0) begin
            rec[set].delete(pos);
        end else begin
            m_miss++;
            if (rec[set].size() == 2) begin
                v = rec[set].pop_back();
                if (cdirty[v]) begin
                    t = '{1'b1, v, cline[v]};
                    exp_q.push_back(t);
                    ref_mem[v] = cline[v];
                end
                cline.delete(v);
                cdirty.delete(v);
            end
            t = '{1'b0, la, 256'b0};
            exp_q.push_back(t);
            cline[la]  = ref_line(la);
            cdirty[la] = 1'b0;
        end
        rec[set].push_front(la);
        m_acc++;
        l = cline[la];
        if (store) begin
            l[w*32 +: 32] = wdata;
            cline[la]  = l;
            cdirty[la] = 1'b1;
        end
        rdata = l[w*32 +: 32];
    endtask

    // One access: drive, wait for stall release, compare against the model.
    task automatic access(input logic [31:0] addr, input bit rd, input bit wr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
        bit          mhit;
        logic [31:0] mdata;
        int          cyc;
        txn_t        o;
        model_access(addr, wr, wdata, mhit, mdata);
        obs_q.delete();
        @(posedge clk_i); #1;
        p1_addr_i     = addr;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_data_i     = wdata;
        cyc = 0;
        @(negedge clk_i);
        while (p1_stall_o && cyc < 200) begin
            cyc++;
            @(negedge clk_i);
        end
        check("stall_timeout", p1_stall_o, 1'b0);
        check("hit_without_stall", (cyc == 0), mhit);
        rdata = p1_data_o;
        if (!wr) check("load_data", p1_data_o, mdata);
        @(posedge clk_i); #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        check("acc_cnt", acc_cnt_o, m_acc);
        check("miss_cnt", miss_cnt_o, m_miss);
        check("txn_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            o = obs_at(i);
            check("txn_kind_addr", {o.wr, o.addr}, {exp_q[i].wr, exp_q[i].addr});
            if (exp_q[i].wr) check("wb_data", o.dat, exp_q[i].dat);
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    logic [31:0]  rd;
    logic [31:0]  acc_before;
    logic [255:0] l40;
    txn_t         o;
    int           cyc;

    initial begin
        l40 = default_line(32'h40);
        l40[31:0] = 32'hDEADBEEF;
        bus_mem[32'h40] = l40;
        ref_mem[32'h40] = l40;

        // Reset state
        #2 rst_i = 1'b0;
        #10;
        check("rst_enable", mem_enable_o, 1'b0);
        check("rst_write", mem_write_o, 1'b0);
        check("rst_acc", acc_cnt_o, 32'd0);
        check("rst_miss", miss_cnt_o, 32'd0);
        check("rst_stall", p1_stall_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        // 1: cold load miss and refill
        access(32'h40, 1, 0, 0, rd);
        check("t1_data", rd, 32'hDEADBEEF);
        check("t1_miss", miss_cnt_o, 32'd1);
        check("t1_acc", acc_cnt_o, 32'd1);
        o = obs_at(0);
        check("t1_refill", {o.wr, o.addr}, {1'b0, 32'h40});

        // 2: both ways of set 2 filled, then hit
        access(32'h040, 1, 0, 0, rd);
        access(32'h440, 1, 0, 0, rd);
        access(32'h040, 1, 0, 0, rd);
        check("t2_no_mem_a", obs_q.size(), 0);
        access(32'h440, 1, 0, 0, rd);
        check("t2_no_mem_b", obs_q.size(), 0);
        check("t2_miss", miss_cnt_o, 32'd2);

        // 3: dirty LRU victim written back before refill
        access(32'h444, 0, 1, 32'h12345678, rd);
        access(32'h040, 1, 0, 0, rd);
        access(32'h840, 1, 0, 0, rd);
        o = obs_at(0);
        check("t3_wb", {o.wr, o.addr}, {1'b1, 32'h440});
        check("t3_wb_word1", o.dat[63:32], 32'h12345678);
        o = obs_at(1);
        check("t3_refill", {o.wr, o.addr}, {1'b0, 32'h840});
        access(32'h040, 1, 0, 0, rd);
        access(32'h840, 1, 0, 0, rd);
        check("t3_acc", acc_cnt_o, 32'd10);

        // 4: store miss on a clean victim, later evicted dirty
        access(32'hC48, 0, 1, 32'hA5A5A5A5, rd);
        check("t4_clean_victim", obs_q.size(), 1);
        access(32'hC48, 1, 0, 0, rd);
        check("t4_data", rd, 32'hA5A5A5A5);
        access(32'h840, 1, 0, 0, rd);
        access(32'h1048, 1, 0, 0, rd);
        o = obs_at(0);
        check("t4_wb", {o.wr, o.addr}, {1'b1, 32'hC40});
        check("t4_wb_word2", o.dat[95:64], 32'hA5A5A5A5);
        check("t4_counts", {miss_cnt_o, acc_cnt_o}, {32'd5, 32'd14});

        // 5: reset during WRITEBACK aborts the transaction
        access(32'h1040, 0, 1, 32'h11112222, rd);
        access(32'h840, 1, 0, 0, rd);
        auto_mem = 1'b0;
        @(posedge clk_i); #1;
        p1_addr_i    = 32'h440;
        p1_MemRead_i = 1'b1;
        cyc = 0;
        @(negedge clk_i);
        while (!(mem_enable_o && mem_write_o) && cyc < 50) begin
            cyc++;
            @(negedge clk_i);
        end
        check("t5_in_wb", {mem_enable_o, mem_write_o}, 2'b11);
        check("t5_wb_addr", mem_addr_o, 32'h1040);
        #2 rst_i = 1'b0;
        #1;
        check("t5_enable_drop", mem_enable_o, 1'b0);
        check("t5_counts_clear", {acc_cnt_o, miss_cnt_o}, 64'd0);
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        auto_mem = 1'b1;
        access(32'h440, 1, 0, 0, rd);
        check("t5_remiss", miss_cnt_o, 32'd1);
        access(32'h444, 1, 0, 0, rd);
        check("t5_earlier_wb", rd, 32'h12345678);

        // 6: read and write together on a hit behave as a store
        acc_before = acc_cnt_o;
        access(32'h444, 1, 1, 32'hCAFEF00D, rd);
        check("t6_acc_inc", acc_cnt_o, acc_before + 32'd1);
        access(32'h444, 1, 0, 0, rd);
        check("t6_data", rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
- Parametrised, two-way set-associative, write-back, write-allocate data cache between the pipeline's MEM stage and the line-wide data memory.
- Generalises the direct-mapped dcache: configurable line width, set count and address width.
- Tag, valid, dirty and data arrays are internal registers, with 1-bit LRU replacement per set.
- Adds hit/miss performance counters and a dirty-victim writeback path that selects between two ways.

Parameters:
- ADDR_W, 32, byte-address width.
- LINE_W, 256, line width in bits; power of two, >= 64.
- SETS, 32, number of sets; power of two, >= 2.
- Derived, not overridable: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W; word select = addr[OFF_W-1:2].

Ports:
- clk_i  in  1  system clock, all state on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mem_data_i  in  LINE_W  refill line from memory.
- mem_ack_i  in  1  memory completion, one-cycle pulse.
- mem_data_o  out  LINE_W  victim line for writeback.
- mem_addr_o  out  ADDR_W  line-aligned memory address; low OFF_W bits are 0.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = writeback, 0 = refill.
- p1_data_i  in  32  store data.
- p1_addr_i  in  ADDR_W  load/store byte address, word aligned.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; has priority if both read and write are set.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  pipeline stall.
- acc_cnt_o  out  32  completed accesses.
- miss_cnt_o  out  32  misses.

Behaviour:
- Reset (rst_i low, asynchronous): all valid, dirty and LRU bits cleared. state = IDLE. mem_enable_o, mem_write_o, acc_cnt_o and miss_cnt_o are 0. Data and tag array contents are don't-care.
- Reset mid-operation: the transaction is aborted, mem_enable_o drops immediately, and no line is written.
- Request and hit:
  - req = p1_MemRead_i | p1_MemWrite_i.
  - hit_w = valid[idx][w] & (tag[idx][w] == addr tag).
  - hit = hit_w0 | hit_w1, valid only in IDLE.
- Stall: p1_stall_o = req & (~hit | state != IDLE). This is combinational. The CPU holds addr, data and controls stable while stalled.
- Load hit: p1_data_o = selected 32-bit word of the hit line, combinational, zero wait cycles. p1_data_o is don't-care when not hitting.
- Store hit: at the clock edge, the word in the hit way is replaced by p1_data_i, other words are unchanged, and dirty is set to 1.
- LRU update: on any completed hit in way w, lru[idx] = ~w.
- Access counter: acc_cnt_o increments on every cycle with req & hit & IDLE.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILLOK.
  - IDLE: req & ~hit -> MISS. miss_cnt_o increments. Victim is latched: way0 if invalid, else way1 if invalid, else lru[idx].
  - MISS: if the victim is valid & dirty -> WRITEBACK with mem_enable=1, mem_write=1. Otherwise -> REFILL with mem_enable=1, mem_write=0.
  - WRITEBACK: mem_addr_o = {victim tag, idx, 0}; mem_data_o = victim line. On mem_ack_i -> REFILL, mem_write=0, mem_enable stays 1.
  - REFILL: mem_addr_o = {req tag, idx, 0}. On mem_ack_i, the victim way is loaded with mem_data_i, tag = req tag, valid = 1, dirty = 0. Then mem_enable = 0 and the FSM -> REFILLOK.
  - REFILLOK: one bubble cycle -> IDLE. The held access then hits; a store then merges and sets dirty.
- mem_enable_o and mem_write_o are registered. They are held stable from assertion until the ack edge. mem_ack_i is ignored outside WRITEBACK and REFILL.
- mem_data_o is the victim line in every state. mem_addr_o is the request line address outside WRITEBACK.
- Counters wrap modulo 2^32. acc_cnt_o counts the replayed hit of a missed access, so hits = acc - miss.
- Both ways miss with both dirty: only the LRU victim is written back.
- A new request in IDLE in the cycle after REFILLOK is evaluated normally.

Test Plan (defaults: OFF_W=5, IDX_W=5, TAG_W=22):
1. Reset, load 0x0000_0040. Memory acks 3 cycles after enable with word0 = 0xDEADBEEF.
   -> mem_addr_o = 0x40, mem_write_o = 0, stall high until the replay.
   -> p1_data_o = 0xDEADBEEF, miss_cnt_o = 1, acc_cnt_o = 1.
2. Load 0x040, then load 0x440 (same set 2, both refill). Re-load 0x040 and 0x440.
   -> no mem_enable_o, stall 0 on both re-loads, miss_cnt_o = 2.
3. Store 0x12345678 to 0x444 (hit, dirty). Load 0x040 (makes 0x440 LRU). Load 0x840.
   -> WRITEBACK with mem_addr_o = 0x440, mem_write_o = 1, mem_data_o word1 = 0x12345678.
   -> then REFILL of 0x840; later loads of 0x040 and 0x840 hit.
4. Store 0xA5A5A5A5 to 0xC48 (miss, clean victim).
   -> refill, then merge into word2; load 0xC48 = 0xA5A5A5A5.
   -> victim eviction later produces a writeback, proving dirty = 1.
5. Drop rst_i during WRITEBACK.
   -> mem_enable_o = 0 immediately, counters = 0; a subsequent load of 0x440 misses.
6. Simultaneous p1_MemRead_i = p1_MemWrite_i = 1 on a hit.
   -> treated as a store; the line is updated and acc_cnt_o increments by 1.
